ddmtd_capture_sequencer: RTL and testbench
==========================================

Name: ddmtd_capture_sequencer

Overview:
- Sequences one capture run from the DDMTD_Array AXI-Stream output into the PS-visible BRAM ports, on the BRAM/AXIS clock domain.
- On arm, it writes a status header word, then accepts exactly N stream beats and writes each beat to a consecutive BRAM address.
- It then reports done and waits to be disarmed.
- Replaces ad-hoc TREADY/address/write-enable logic with a single defined handshake.

Parameters:
- DATA_WIDTH, 32, bits per DDMTD channel word
- NUM_DDMTD, 24, channels per stream beat; beat width = DATA_WIDTH*NUM_DDMTD
- BEAT_BYTES, 32, BRAM byte-address increment per beat (per BRAM controller)
- MAX_WORDS, 1024, upper clamp on beats per run
- HDR_WIDTH, 256, header (status) word width

Ports:
- CLK, in, 1: BRAM/AXIS clock; all logic on rising edge
- RESETN, in, 1: synchronous reset, active low
- arm, in, 1: level run request (GPIO bit); rising level starts a run, low aborts or disarms
- words_req, in, 32: beats requested; sampled on arm start
- status_in, in, HDR_WIDTH: header contents (reset flag, clk counter, firmware version, PROG_FULL); sampled on arm start
- s_axis_tvalid, in, 1: stream valid from DDMTD_Array
- s_axis_tdata, in, DATA_WIDTH*NUM_DDMTD: stream data
- s_axis_tready, out, 1: ready to DDMTD_Array
- hdr_we, out, 1: header BRAM write strobe
- hdr_din, out, HDR_WIDTH: header write data
- bram_we, out, 1: data BRAM write strobe (all bytes)
- bram_addr, out, 32: byte address for header and data writes
- bram_din, out, DATA_WIDTH*NUM_DDMTD: data write data
- busy, out, 1: run in progress
- done, out, 1: run completed; held until arm low
- aborted, out, 1: last run aborted by arm drop; cleared on next start
- clamped, out, 1: words_req exceeded MAX_WORDS on last start
- word_count, out, 32: beats written in current/last run

Behaviour:
- Reset (RESETN=0 at clock edge): state=IDLE; all outputs 0, including the addr, din and count registers.
- State IDLE:
  - arm=1 and done=0 -> go to HDR.
  - On that transition: latch N = min(words_req, MAX_WORDS); set clamped = (words_req > MAX_WORDS); latch hdr_din = status_in; clear aborted; clear word_count.
  - busy=1 from the next cycle.
- State HDR (exactly 1 cycle):
  - hdr_we=1, bram_addr=0.
  - Next state: N=0 -> DONE; otherwise -> CAP.
- State CAP:
  - s_axis_tready=1 while word_count + accepted-in-flight < N. Deassert combinationally from the registered count so that no beat beyond N is accepted.
  - Transfer occurs when tvalid & tready.
  - Each transfer registers its beat. Exactly one cycle later: bram_we=1, bram_din = beat, bram_addr = k*BEAT_BYTES, where k = 0..N-1 is the transfer index. word_count increments in the same cycle.
  - Write latency = 1 cycle; back-to-back transfers produce back-to-back writes.
  - Gaps in tvalid produce gaps in bram_we; no timeout.
  - After the write of index N-1 -> DONE.
- State DONE:
  - busy=0, done=1, s_axis_tready=0.
  - Remain in DONE while arm=1.
  - arm=0 -> IDLE and clear done. Re-arming requires arm low for at least 1 cycle.
- Abort (arm=0 while in HDR or CAP):
  - Next state IDLE; tready=0 immediately that cycle; aborted=1; busy=0; done=0.
  - A transfer accepted in the abort cycle is still written (write pipeline drains). word_count keeps the value reached.
- Address arithmetic: 32-bit, no wrap within MAX_WORDS*BEAT_BYTES. bram_addr holds its last value when idle.
- tvalid=1 during IDLE/HDR/DONE is never accepted; the upstream FIFO holds the data.
- Simultaneous RESETN=0 and any other event: reset wins.

Test Plan:
- Reset then arm=1, words_req=4, tvalid constant:
  - hdr_we pulse at addr 0 with hdr_din = status_in.
  - 4 consecutive bram_we with addr 0, 32, 64, 96; data matches beats 0..3.
  - Exactly 4 tready&tvalid handshakes; done=1, word_count=4.
- words_req=3, tvalid toggling 1,0,0,1,0,1 -> 3 writes, each 1 cycle after its handshake; tready drops after the 3rd transfer; done=1.
- words_req=5000 -> clamped=1, N=1024; last write at addr 32736; word_count=1024.
- words_req=0 -> header written, no data handshakes, done=1 two cycles after arm.
- arm dropped after 2 of 8 transfers -> tready=0 that cycle, aborted=1, word_count=2 (or 3 if a transfer occurred on the drop cycle), no further writes. Re-arm then starts a fresh run at addr 0.
- arm held high after done -> no new run. RESETN=0 mid-CAP -> all outputs 0 on the next edge; the run does not resume.

Source files
------------

// File: rtl/ddmtd_capture_sequencer.sv
// Capture run sequencer: header word, then N stream beats into BRAM.
// Ports: CLK/RESETN, arm/words_req/status_in, s_axis_*, hdr_*, bram_*, status flags.
module ddmtd_capture_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DDMTD  = 24,
  parameter int BEAT_BYTES = 32,
  parameter int MAX_WORDS  = 1024,
  parameter int HDR_WIDTH  = 256
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic                            arm,
  input  logic [31:0]                     words_req,
  input  logic [HDR_WIDTH-1:0]            status_in,
  input  logic                            s_axis_tvalid,
  input  logic [DATA_WIDTH*NUM_DDMTD-1:0] s_axis_tdata,
  output logic                            s_axis_tready,
  output logic                            hdr_we,
  output logic [HDR_WIDTH-1:0]            hdr_din,
  output logic                            bram_we,
  output logic [31:0]                     bram_addr,
  output logic [DATA_WIDTH*NUM_DDMTD-1:0] bram_din,
  output logic                            busy,
  output logic                            done,
  output logic                            aborted,
  output logic                            clamped,
  output logic [31:0]                     word_count
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);
  localparam logic [31:0] BSTEP = 32'(BEAT_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    CAP,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] n_words;
  logic        xfer;
  logic [31:0] beat_addr;

  // word_count advances on the same edge that registers the beat,
  // so it already covers the one write in flight.
  assign s_axis_tready = (state == CAP) && arm
                       && (word_count < n_words);
  assign xfer      = s_axis_tready & s_axis_tvalid;
  assign beat_addr = word_count * BSTEP;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state      <= IDLE;
      n_words    <= '0;
      hdr_we     <= 1'b0;
      hdr_din    <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      clamped    <= 1'b0;
      word_count <= '0;
    end else begin
      hdr_we  <= 1'b0;
      bram_we <= 1'b0;

      if (xfer) begin
        bram_we    <= 1'b1;
        bram_din   <= s_axis_tdata;
        bram_addr  <= beat_addr;
        word_count <= word_count + 32'd1;
      end

      unique case (state)
        IDLE: begin
          if (arm && !done) begin
            state      <= HDR;
            busy       <= 1'b1;
            hdr_we     <= 1'b1;
            hdr_din    <= status_in;
            bram_addr  <= '0;
            aborted    <= 1'b0;
            word_count <= '0;
            clamped    <= (words_req > MAX_W);
            n_words    <= (words_req > MAX_W) ? MAX_W
                                              : words_req;
          end
        end
        HDR: begin
          if (!arm) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (n_words == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= CAP;
          end
        end
        CAP: begin
          // Completion wins over a late arm drop: all beats are in.
          if (word_count == n_words) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!arm) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end
        end
        DONE: begin
          if (!arm) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddmtd_capture_sequencer.sv
// Directed bench for ddmtd_capture_sequencer.
// Scenario tasks drive runs and compare against hand-derived values.
module tb_ddmtd_capture_sequencer;

  localparam int NUM = 24;
  localparam int BW  = 32 * NUM;
  localparam int HW  = 256;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic          arm;
  logic [31:0]   words_req;
  logic [HW-1:0] status_in;
  logic          s_axis_tvalid;
  logic [BW-1:0] s_axis_tdata;
  logic          s_axis_tready;
  logic          hdr_we;
  logic [HW-1:0] hdr_din;
  logic          bram_we;
  logic [31:0]   bram_addr;
  logic [BW-1:0] bram_din;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          clamped;
  logic [31:0]   word_count;

  ddmtd_capture_sequencer dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .arm           (arm),
    .words_req     (words_req),
    .status_in     (status_in),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .hdr_we        (hdr_we),
    .hdr_din       (hdr_din),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .clamped       (clamped),
    .word_count    (word_count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [31:0]   wr_addr[$];
  logic [BW-1:0] wr_data[$];
  int            wr_cyc[$];
  int            hs_cyc[$];
  int            hdr_cnt;
  logic [31:0]   hdr_addr;
  logic [HW-1:0] hdr_data;
  int            done_cyc;
  logic          drop_tready;

  localparam logic [HW-1:0] STAT_A = {8{32'h5A5A_0001}};
  localparam logic [HW-1:0] STAT_B = {8{32'h1234_ABCD}};

  function automatic logic [BW-1:0] beat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {NUM{w}};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives ncyc cycles and records writes, handshakes and header events.
  // pat gives tvalid per cycle (bit c%6) when use_pat; drop_after>=0
  // drops arm once that many handshakes have happened.
  task automatic drive(input int ncyc, input bit use_pat,
                       input logic [5:0] pat, input int drop_after);
    int hs;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    hs_cyc.delete();
    hdr_cnt     = 0;
    hdr_addr    = '1;
    hdr_data    = '0;
    done_cyc    = -1;
    drop_tready = 1'bx;
    hs = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (bram_we) begin
        wr_addr.push_back(bram_addr);
        wr_data.push_back(bram_din);
        wr_cyc.push_back(c);
      end
      if (hdr_we) begin
        hdr_cnt++;
        hdr_addr = bram_addr;
        hdr_data = hdr_din;
      end
      if (done && done_cyc < 0) done_cyc = c;
      s_axis_tvalid = use_pat ? pat[c % 6] : 1'b1;
      s_axis_tdata  = beat(hs);
      if (drop_after >= 0 && hs == drop_after && arm) begin
        arm = 1'b0;
        #1;
        drop_tready = s_axis_tready;
      end
      #1;
      if (s_axis_tready && s_axis_tvalid) begin
        hs++;
        hs_cyc.push_back(c);
      end
      step();
    end
  endtask

  task automatic disarm();
    arm = 1'b0;
    s_axis_tvalid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    arm = 1'b0;
    words_req = '0;
    status_in = '0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = beat(99);
    step();
    step();
    checks++;
    if ({s_axis_tready, hdr_we, bram_we, busy, done, aborted,
         clamped} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
               {s_axis_tready, hdr_we, bram_we, busy, done,
                aborted, clamped});
    end
    checks++;
    if (bram_addr !== 32'd0 || word_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: addr %0h wc %0h want 0",
               bram_addr, word_count);
    end
    checks++;
    if (hdr_din !== '0 || bram_din !== '0) begin
      errors++;
      $display("FAIL reset_din: hdr %0h din %0h want 0",
               hdr_din, bram_din);
    end
    RESETN = 1'b1;
    s_axis_tvalid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    words_req = 32'd4;
    status_in = STAT_A;
    arm = 1'b1;
    drive(12, 1'b0, 6'b0, -1);
    checks++;
    if (hdr_cnt !== 1 || hdr_addr !== 32'd0) begin
      errors++;
      $display("FAIL basic_hdr: cnt %0d addr %0h want 1/0",
               hdr_cnt, hdr_addr);
    end
    checks++;
    if (hdr_data !== STAT_A) begin
      errors++;
      $display("FAIL basic_hdr_din: got %0h want %0h",
               hdr_data, STAT_A);
    end
    checks++;
    if (hs_cyc.size() !== 4 || wr_addr.size() !== 4) begin
      errors++;
      $display("FAIL basic_counts: hs %0d wr %0d want 4/4",
               hs_cyc.size(), wr_addr.size());
    end
    for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== 32'(i * 32) || wr_data[i] !== beat(i)) begin
        errors++;
        $display("FAIL basic_wr%0d: addr %0h want %0h", i,
                 wr_addr[i], i * 32);
      end
    end
    checks++;
    if (wr_addr.size() == 4 && (wr_cyc[0] !== 3 || wr_cyc[3] !== 6)) begin
      errors++;
      $display("FAIL basic_b2b: cycles %0d..%0d want 3..6",
               wr_cyc[0], wr_cyc[3]);
    end
    checks++;
    if (done !== 1'b1 || word_count !== 32'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done %b wc %0d busy %b want 1/4/0",
               done, word_count, busy);
    end
  endtask

  task automatic test_hold_after_done();
    drive(10, 1'b0, 6'b0, -1);
    checks++;
    if (hs_cyc.size() !== 0 || hdr_cnt !== 0 || wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL hold: hs %0d hdr %0d wr %0d want 0",
               hs_cyc.size(), hdr_cnt, wr_addr.size());
    end
    checks++;
    if (done !== 1'b1 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL hold_done: done %b tready %b want 1/0",
               done, s_axis_tready);
    end
    disarm();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL disarm: done %b want 0", done);
    end
  endtask

  task automatic test_gaps();
    words_req = 32'd3;
    status_in = STAT_B;
    arm = 1'b1;
    drive(20, 1'b1, 6'b101001, -1);
    checks++;
    if (hs_cyc.size() !== 3 || wr_addr.size() !== 3) begin
      errors++;
      $display("FAIL gaps_counts: hs %0d wr %0d want 3/3",
               hs_cyc.size(), wr_addr.size());
    end
    for (int i = 0; i < 3 && i < wr_cyc.size()
                        && i < hs_cyc.size(); i++) begin
      checks++;
      if (wr_cyc[i] !== hs_cyc[i] + 1 || wr_data[i] !== beat(i)
          || wr_addr[i] !== 32'(i * 32)) begin
        errors++;
        $display("FAIL gaps_wr%0d: wcyc %0d hcyc %0d addr %0h",
                 i, wr_cyc[i], hs_cyc[i], wr_addr[i]);
      end
    end
    s_axis_tvalid = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL gaps_end: tready %b done %b want 0/1",
               s_axis_tready, done);
    end
    disarm();
  endtask

  task automatic test_clamp();
    words_req = 32'd5000;
    arm = 1'b1;
    drive(1040, 1'b0, 6'b0, -1);
    checks++;
    if (clamped !== 1'b1 || word_count !== 32'd1024) begin
      errors++;
      $display("FAIL clamp: clamped %b wc %0d want 1/1024",
               clamped, word_count);
    end
    checks++;
    if (wr_addr.size() !== 1024) begin
      errors++;
      $display("FAIL clamp_wr: got %0d want 1024", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[1023] !== 32'd32736 || wr_data[1023] !== beat(1023)) begin
        errors++;
        $display("FAIL clamp_last: addr %0d want 32736",
                 wr_addr[1023]);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL clamp_done: got %b want 1", done);
    end
    disarm();
  endtask

  task automatic test_zero();
    words_req = 32'd0;
    arm = 1'b1;
    drive(8, 1'b0, 6'b0, -1);
    checks++;
    if (hdr_cnt !== 1 || hs_cyc.size() !== 0 || wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL zero: hdr %0d hs %0d wr %0d want 1/0/0",
               hdr_cnt, hs_cyc.size(), wr_addr.size());
    end
    checks++;
    if (done_cyc !== 2 || clamped !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: cyc %0d clamped %b want 2/0",
               done_cyc, clamped);
    end
    disarm();
  endtask

  task automatic test_abort_rearm();
    words_req = 32'd8;
    arm = 1'b1;
    drive(12, 1'b0, 6'b0, 2);
    checks++;
    if (drop_tready !== 1'b0) begin
      errors++;
      $display("FAIL abort_tready: got %b want 0", drop_tready);
    end
    checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: ab %b busy %b done %b want 1/0/0",
               aborted, busy, done);
    end
    checks++;
    if (word_count !== 32'd2 || wr_addr.size() !== 2) begin
      errors++;
      $display("FAIL abort_cnt: wc %0d wr %0d want 2/2",
               word_count, wr_addr.size());
    end
    words_req = 32'd2;
    arm = 1'b1;
    drive(10, 1'b0, 6'b0, -1);
    checks++;
    if (wr_addr.size() !== 2 || hdr_cnt !== 1) begin
      errors++;
      $display("FAIL rearm_cnt: wr %0d hdr %0d want 2/1",
               wr_addr.size(), hdr_cnt);
    end else begin
      checks++;
      if (wr_addr[0] !== 32'd0 || wr_data[0] !== beat(0)) begin
        errors++;
        $display("FAIL rearm_addr: got %0h want 0", wr_addr[0]);
      end
    end
    checks++;
    if (aborted !== 1'b0 || done !== 1'b1 || word_count !== 32'd2) begin
      errors++;
      $display("FAIL rearm_flags: ab %b done %b wc %0d want 0/1/2",
               aborted, done, word_count);
    end
    disarm();
  endtask

  task automatic test_reset_mid_cap();
    words_req = 32'd8;
    arm = 1'b1;
    drive(4, 1'b0, 6'b0, -1);
    checks++;
    if (busy !== 1'b1 || word_count !== 32'd2) begin
      errors++;
      $display("FAIL midcap_pre: busy %b wc %0d want 1/2",
               busy, word_count);
    end
    RESETN = 1'b0;
    arm = 1'b0;
    step();
    checks++;
    if ({s_axis_tready, hdr_we, bram_we, busy, done, aborted,
         clamped} !== 7'b0 || word_count !== 32'd0
        || bram_addr !== 32'd0 || bram_din !== '0) begin
      errors++;
      $display("FAIL midcap_rst: busy %b we %b wc %0d addr %0h",
               busy, bram_we, word_count, bram_addr);
    end
    RESETN = 1'b1;
    drive(5, 1'b0, 6'b0, -1);
    checks++;
    if (wr_addr.size() !== 0 || busy !== 1'b0 || word_count !== 32'd0) begin
      errors++;
      $display("FAIL midcap_noresume: wr %0d busy %b wc %0d",
               wr_addr.size(), busy, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_after_done();
    test_gaps();
    test_clamp();
    test_zero();
    test_abort_rearm();
    test_reset_mid_cap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
